if_prefetch: RTL

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/mips32_pkg.sv | 25 ++
 rtl/if_prefetch_if.sv | 41 ++++
 rtl/if_prefetch_inst_fifo.sv | 63 ++++++
 rtl/if_prefetch.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// mips32_pkg: shared constants and types for the MIPS32 front end.
//   INST_W / ADDR_W : instruction and address widths
//   PC_STEP         : byte distance between consecutive fetches
//   RESET_PC_DEF    : default first fetch address after reset
//   fetch_entry_t   : one prefetch queue entry, {pc, inst}
package mips32_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int ENTRY_W = ADDR_W + INST_W;

  localparam logic [ADDR_W-1:0] PC_STEP      = 32'd4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2^32 (FFFF_FFFC -> 0).
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// if_prefetch_if: bus bundle between the prefetcher, instruction memory,
// the redirect source and the decode stage.
//   master : the prefetcher (drives ice/iaddr and the decode-side outputs)
//   slave  : the surrounding environment (memory, redirect, decode)
// Signals:
//   ice, iaddr          fetch request and its address
//   inst                read data, valid one cycle after ice
//   redirect, redirect_pc  flush and new fetch address
//   id_ready            decode accepts the head entry
//   id_valid, id_pc, id_inst  head entry presented to decode
//   occupancy           entries held in the queue
interface if_prefetch_if
  import mips32_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              ice;
  logic [ADDR_W-1:0] iaddr;
  logic [INST_W-1:0] inst;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_ready;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output ice, iaddr, id_valid, id_pc, id_inst, occupancy,
    input  inst, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  ice, iaddr, id_valid, id_pc, id_inst, occupancy,
    output inst, redirect, redirect_pc, id_ready
  );

endinterface

// File: rtl/if_prefetch_inst_fifo.sv
// inst_fifo: circular FIFO holding fetched {pc, inst} entries.
// Parameters:
//   DEPTH : number of entries, power of two, at least 2
//   WIDTH : entry width in bits
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   flush       empties the queue; wins over push and pop
//   push, wdata write one entry at the tail
//   pop         drop the head entry
//   rdata       head entry (meaningful when empty=0)
//   empty       no entries held
//   count       entries held, 0..DEPTH
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetch unit. Issues sequential fetches to
// instruction memory while the queue has room, captures each response one
// cycle later together with its PC, and presents the oldest entry to decode
// with a valid/ready handshake. A redirect flushes the queue, drops the
// in-flight response and restarts fetch at redirect_pc.
// Parameters:
//   DEPTH    : queue entries, power of two, at least 2
//   RESET_PC : first fetch address after reset
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : if_prefetch_if.master (fetch, redirect and decode signals)
// Build option:
//   IF_PREFETCH_BYPASS_EN : when defined, a response arriving into an empty
//   queue is shown to decode in its arrival cycle, and consumed without a
//   push if decode is ready. Default build: every response is queued first.
module if_prefetch
  import mips32_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  if_prefetch_if.master bus
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W:0] DEPTH_LIM = (OCC_W+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] issued_pc_q;
  logic              in_flight_q;
  logic              discard_q;

  logic              issue;
  logic [OCC_W:0]    pending;
  logic              rsp_valid;
  logic              bypass;

  logic              fifo_flush;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [OCC_W-1:0]  fifo_count;
  fetch_entry_t      rsp_entry;
  fetch_entry_t      head;

  // Queue slots already spoken for: held entries plus the response on its way.
  assign pending = {1'b0, fifo_count} + {{OCC_W{1'b0}}, in_flight_q};

  // rst_n is part of the issue term so ice falls the moment reset asserts.
  assign issue = rst_n && !bus.redirect && (pending < DEPTH_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      issued_pc_q <= '0;
      in_flight_q <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      in_flight_q <= issue;
      // Whatever returns in the cycle after a redirect belongs to the old
      // instruction stream.
      discard_q   <= bus.redirect;
      if (issue) issued_pc_q <= pc_q;
      if (bus.redirect)   pc_q <= bus.redirect_pc;
      else if (issue)     pc_q <= next_pc(pc_q);
    end
  end

  // A response landing in a redirect cycle is stale as well.
  assign rsp_valid = in_flight_q && !discard_q && !bus.redirect;

`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass = rsp_valid && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign rsp_entry.pc   = issued_pc_q;
  assign rsp_entry.inst = bus.inst;

  assign fifo_flush = bus.redirect;
  assign fifo_push  = rsp_valid && !(bypass && bus.id_ready);
  assign fifo_pop   = !fifo_empty && bus.id_ready && !bus.redirect;

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_inst_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (rsp_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.id_valid  = !fifo_empty || bypass;
  assign bus.ice       = issue;
  assign bus.iaddr     = pc_q;
  assign bus.occupancy = fifo_count;

  // Zero when nothing is presented, which also covers the reset state.
  always_comb begin
    bus.id_pc   = '0;
    bus.id_inst = '0;
    if (!fifo_empty) begin
      bus.id_pc   = head.pc;
      bus.id_inst = head.inst;
    end else if (bypass) begin
      bus.id_pc   = issued_pc_q;
      bus.id_inst = bus.inst;
    end
  end

endmodule
